// File: rtl/bus_target_mem.sv
// Bus responder: decodes a word window of the bus address space onto a RAM, with wait states
// and a 4-phase ready handshake. Optional fault pulse on misses: define BUS_TARGET_FAULT_EN.
module bus_target_mem #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0001_0000,
    parameter int unsigned       DEPTH_LOG2  = 8,
    parameter int unsigned       WAIT_STATES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bus_clk,
    input  logic              i_bus_we,
    input  logic [ADDR_W-1:0] i_bus_addr,
    input  logic [DATA_W-1:0] i_bus_data,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_data_ready
`ifdef BUS_TARGET_FAULT_EN
    ,
    output logic              o_fault
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                  lat_we_q;
    logic                  lat_hit_q;
    logic [DEPTH_LOG2-1:0] lat_idx_q;
    logic [DATA_W-1:0]     lat_data_q;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;

    logic latch, access, ack_done, mem_we;

    // Wrapping subtraction makes addresses below the base land far outside the window.
    logic [ADDR_W-1:0] offset;
    logic              hit;

    assign offset = i_bus_addr - BASE_ADDR;
    assign hit    = (offset[ADDR_W-1:DEPTH_LOG2] == '0);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (i_bus_clk && !ready_q) state_d = StWait;
            StWait: begin
                if (!i_bus_clk) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end
            end
            StAck:  if (!i_bus_clk) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: decoded strobes and wait counter
    always_comb begin
        latch    = 1'b0;
        access   = 1'b0;
        ack_done = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                latch = i_bus_clk && !ready_q;
                if (latch) cnt_d = 4'(WAIT_STATES);
            end
            StWait: begin
                access = i_bus_clk && (cnt_q == 4'd0);
                if (i_bus_clk && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
            end
            StAck: ack_done = !i_bus_clk;
            default: ;
        endcase
    end

    // Request capture; later changes on the bus are ignored until the next access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lat_we_q   <= 1'b0;
            lat_hit_q  <= 1'b0;
            lat_idx_q  <= '0;
            lat_data_q <= '0;
        end else if (latch) begin
            lat_we_q   <= i_bus_we;
            lat_hit_q  <= hit;
            lat_idx_q  <= offset[DEPTH_LOG2-1:0];
            lat_data_q <= i_bus_data;
        end
    end

    assign mem_we = access && lat_we_q && lat_hit_q;

    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[lat_idx_q] <= lat_data_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (access && !lat_we_q) rdata_d = lat_hit_q ? mem_q[lat_idx_q] : '0;
        ready_d = ready_q;
        if (access) begin
            ready_d = 1'b1;
        end else if (ack_done) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    assign o_bus_data       = rdata_q;
    assign o_bus_data_ready = ready_q;

`ifdef BUS_TARGET_FAULT_EN
    logic fault_q;

    // Single-cycle pulse aligned with the ready rise of a missed access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= access && !lat_hit_q;
        end
    end

    assign o_fault = fault_q;
`endif

endmodule

// File: tb/tb_bus_target_mem.sv
// Scoreboard bench for bus_target_mem: one instance with 2 wait states, one with none.
module tb_bus_target_mem;

    localparam int WS0 = 2;
    localparam int WS1 = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_clk   [2];
    logic        bus_we    [2];
    logic [31:0] bus_addr  [2];
    logic [31:0] bus_wdata [2];
    logic [31:0] rdata     [2];
    logic        rdy       [2];
`ifdef BUS_TARGET_FAULT_EN
    logic        fault     [2];
`endif

    always #5 clk = ~clk;

    bus_target_mem #(.WAIT_STATES(WS0)) dut0 (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_bus_clk        (bus_clk[0]),
        .i_bus_we         (bus_we[0]),
        .i_bus_addr       (bus_addr[0]),
        .i_bus_data       (bus_wdata[0]),
        .o_bus_data       (rdata[0]),
        .o_bus_data_ready (rdy[0])
`ifdef BUS_TARGET_FAULT_EN
        ,
        .o_fault          (fault[0])
`endif
    );

    bus_target_mem #(.WAIT_STATES(WS1)) dut1 (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_bus_clk        (bus_clk[1]),
        .i_bus_we         (bus_we[1]),
        .i_bus_addr       (bus_addr[1]),
        .i_bus_data       (bus_wdata[1]),
        .o_bus_data       (rdata[1]),
        .o_bus_data_ready (rdy[1])
`ifdef BUS_TARGET_FAULT_EN
        ,
        .o_fault          (fault[1])
`endif
    );

    typedef struct {
        int          d;
        logic [31:0] data;
        int          rise;
        bit          miss;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] last_rd [2];
    logic        rdy_prev [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per ready rise.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdy[d] === 1'b1 && rdy_prev[d] !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: dut%0d raised ready with nothing outstanding", d);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_dut", 32'(d), 32'(e.d));
                    check("resp_data", rdata[d], e.data);
                    check("resp_latency_edge", 32'(cyc), 32'(e.rise));
`ifdef BUS_TARGET_FAULT_EN
                    check("fault_pulse", 32'(fault[d]), 32'(e.miss));
`endif
                end
            end
`ifdef BUS_TARGET_FAULT_EN
            else begin
                check("fault_idle", 32'(fault[d]), 32'd0);
            end
`endif
            rdy_prev[d] <= rdy[d];
        end
    end

    task automatic bus_access(input int d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd,
                              input bit miss, input int hold);
        exp_t e;
        int   waited;
        @(negedge clk);
        bus_clk[d]   = 1'b1;
        bus_we[d]    = we;
        bus_addr[d]  = addr;
        bus_wdata[d] = wdata;
        e.d    = d;
        e.data = we ? last_rd[d] : exp_rd;
        e.rise = cyc + 2 + ((d == 0) ? WS0 : WS1);
        e.miss = miss;
        if (!we) last_rd[d] = exp_rd;
        exp_q.push_back(e);
        waited = 0;
        @(negedge clk);
        while (rdy[d] !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (rdy[d] !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: dut%0d addr %h got no ready, expected ready", d, addr);
            exp_q.delete();
            bus_clk[d] = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            bus_addr[d]  = 32'h0001_0000 + 32'(i);
            bus_wdata[d] = 32'hA5A5_0000 + 32'(i);
            bus_we[d]    = ~we;
            @(negedge clk);
            check("hold_ready", 32'(rdy[d]), 32'd1);
            check("hold_data", rdata[d], e.data);
        end
        bus_clk[d] = 1'b0;
        @(negedge clk);
        check("ready_drop", 32'(rdy[d]), 32'd0);
    endtask

    task automatic abort_write(input int d, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus_clk[d]   = 1'b1;
        bus_we[d]    = 1'b1;
        bus_addr[d]  = addr;
        bus_wdata[d] = wdata;
        @(negedge clk);
        bus_clk[d] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_ready", 32'(rdy[d]), 32'd0);
        end
        check("abort_data_kept", rdata[d], last_rd[d]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            bus_clk[d]   = 1'b0;
            bus_we[d]    = 1'b0;
            bus_addr[d]  = '0;
            bus_wdata[d] = '0;
            last_rd[d]   = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", 32'(rdy[d]), 32'd0);
            check("reset_data", rdata[d], 32'd0);
`ifdef BUS_TARGET_FAULT_EN
            check("reset_fault", 32'(fault[d]), 32'd0);
`endif
        end
        rst = 1'b0;

        // Reset during the wait phase of a write must leave RAM untouched.
        bus_access(0, 1'b1, 32'h0001_0005, 32'h55AA_0005, 32'h0, 1'b0, 0);
        bus_access(0, 1'b0, 32'h0001_0005, 32'h0, 32'h55AA_0005, 1'b0, 0);
        @(negedge clk);
        bus_clk[0]   = 1'b1;
        bus_we[0]    = 1'b1;
        bus_addr[0]  = 32'h0001_0005;
        bus_wdata[0] = 32'hBADB_AD05;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_ready", 32'(rdy[0]), 32'd0);
        check("midreset_data", rdata[0], 32'd0);
        bus_clk[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_ready_held", 32'(rdy[0]), 32'd0);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        bus_access(0, 1'b0, 32'h0001_0005, 32'h0, 32'h55AA_0005, 1'b0, 0);

        // Write then read back with 2 wait states.
        bus_access(0, 1'b1, 32'h0001_0003, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        bus_access(0, 1'b0, 32'h0001_0003, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // Misses below and above the window.
        bus_access(0, 1'b0, 32'h0000_FFFF, 32'h0, 32'h0, 1'b1, 0);
        bus_access(0, 1'b0, 32'h0001_0003, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        bus_access(0, 1'b0, 32'h0001_0100, 32'h0, 32'h0, 1'b1, 0);
        bus_access(0, 1'b1, 32'h0001_0100, 32'h1111_2222, 32'h0, 1'b1, 0);

        // Strobe held for 10 cycles past ready while the bus inputs wander.
        bus_access(0, 1'b0, 32'h0001_0003, 32'h0, 32'hDEAD_BEEF, 1'b0, 10);

        // Aborted write leaves the old value.
        bus_access(0, 1'b1, 32'h0001_0007, 32'hCAFE_0007, 32'h0, 1'b0, 0);
        abort_write(0, 32'h0001_0007, 32'h1234_5678);
        bus_access(0, 1'b0, 32'h0001_0007, 32'h0, 32'hCAFE_0007, 1'b0, 0);

        // Zero wait states: fill the whole window, then read it back.
        for (int i = 0; i < 256; i++) begin
            bus_access(1, 1'b1, 32'h0001_0000 + 32'(i), 32'h0001_0000 + 32'(i), 32'h0, 1'b0, 0);
        end
        for (int i = 0; i < 256; i++) begin
            bus_access(1, 1'b0, 32'h0001_0000 + 32'(i), 32'h0, 32'h0001_0000 + 32'(i), 1'b0, 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
